// File: rtl/cosim_stim_gen_pkg.sv
// cosim_stim_pkg: shared types and constants for the cosim stimulus generator.
// The WALK state only exists when COSIM_STIM_WALK_EN is defined.
package cosim_stim_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam logic [31:0] SEED_INC  = 32'h9E3779B9;
  localparam int          NLANES    = 4;
  localparam int          LANE_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef COSIM_STIM_WALK_EN
    ST_WALK = 2'd1,
`endif
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Per-lane seed; an all-zero seed would lock the LFSR, so it becomes 1.
  function automatic logic [31:0] lane_seed(input logic [31:0] base, input int unsigned idx);
    logic [31:0] s;
    s = base + SEED_INC * 32'(idx);
    if (s == 32'h0) s = 32'h1;
    return s;
  endfunction

  // One Galois step of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/cosim_stim_gen_lfsr32.sv
// cosim_lfsr32: one 32-bit Galois LFSR lane with seed reload and step enable.
module cosim_lfsr32
  import cosim_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] value_o
);

  logic [31:0] value_q, value_d;

  // Reload has priority over stepping; otherwise hold.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves value_d unassigned (latch).
    value_d = value_q;
    if (load_i)      value_d = SEED;
    else if (step_i) value_d = lfsr_step(value_q);
  end

  // Lane register; resets to its own seed so the first beat is ready immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments for flops keep all registers updating from pre-edge values.
    if (rst) value_q <= SEED;
    else     value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/cosim_stim_gen.sv
// cosim_stim_gen: seeded 128-bit stimulus source over valid/ready.
// Optional feature macro: COSIM_STIM_WALK_EN (adds a 128-beat walking-one preamble).
module cosim_stim_gen
  import cosim_stim_pkg::*;
#(
  parameter int unsigned NVEC = 256,
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         done,
  output logic [15:0]  vec_count
);

  state_e                     state_q, state_d;
  logic [15:0]                vec_count_q, vec_count_d;
  logic [NLANES*LANE_W-1:0]   lanes;
  logic                       lane_load, lane_step, accept;
`ifdef COSIM_STIM_WALK_EN
  logic [6:0]                 walk_idx_q, walk_idx_d;
`endif

  assign accept = out_valid && out_ready;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    cosim_lfsr32 #(.SEED(lane_seed(SEED, i))) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load_i  (lane_load),
      .step_i  (lane_step),
      .value_o (lanes[i*LANE_W +: LANE_W])
    );
  end

  // Next-state, counter and lane control.
  always_comb begin
    state_d     = state_q;
    vec_count_d = vec_count_q;
    lane_load   = 1'b0;
    lane_step   = 1'b0;
`ifdef COSIM_STIM_WALK_EN
    walk_idx_d  = walk_idx_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          lane_load   = 1'b1;
          vec_count_d = 16'h0;
`ifdef COSIM_STIM_WALK_EN
          walk_idx_d  = 7'd0;
          state_d     = ST_WALK;
`else
          state_d     = ST_RUN;
`endif
        end
      end
`ifdef COSIM_STIM_WALK_EN
      ST_WALK: begin
        if (accept) begin
          walk_idx_d = walk_idx_q + 7'd1;
          if (walk_idx_q == 7'd127) state_d = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
        if (accept) begin
          lane_step   = 1'b1;
          vec_count_d = vec_count_q + 16'd1;
          if (vec_count_q == 16'(NVEC - 1)) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and walk index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vec_count_q <= 16'h0;
`ifdef COSIM_STIM_WALK_EN
      walk_idx_q  <= 7'd0;
`endif
    end else begin
      state_q     <= state_d;
      vec_count_q <= vec_count_d;
`ifdef COSIM_STIM_WALK_EN
      walk_idx_q  <= walk_idx_d;
`endif
    end
  end

  // Output mux; decoded straight from registers so reset clears outputs without a clock.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    done      = (state_q == ST_DONE);
    if (state_q == ST_RUN) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_data  = lanes;
    end
`ifdef COSIM_STIM_WALK_EN
    if (state_q == ST_WALK) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_data  = {127'b0, 1'b1} << walk_idx_q;
    end
`endif
  end

  assign vec_count = vec_count_q;

endmodule

// File: doc/cosim_stim_gen.md
# cosim_stim_gen

Stimulus generator that sits directly upstream of the generate-nesting cosim spec modules. It produces the 128-bit `in` vector those modules unpack into the A0..A9 / B0..B9 nibble fields. The vector comes from four parallel 32-bit LFSR lanes and is delivered over a valid/ready handshake for a programmed number of beats. The run is reproducible from a seed, so simulator and SV-model runs see identical stimulus.

## Interface
Parameters:
- `NVEC`, default 256: beats per run in the RUN phase; legal range 1..65535.
- `SEED`, default 32'h1: base seed for the LFSR lanes.

Ports:
- `clk`, input, 1: the block's single clock.
- `rst`, input, 1: reset, asynchronous and active-high.
- `start`, input, 1: begin a run; sampled in IDLE or DONE only.
- `out_ready`, input, 1: consumer accepts the current beat.
- `out_valid`, output, 1: `out_data` holds a beat.
- `out_data`, output, 128: stimulus vector; bits 79:0 map to {B9..B0, A9..A0} in the consumer.
- `busy`, output, 1: high in WALK or RUN.
- `done`, output, 1: high in DONE.
- `vec_count`, output, 16: RUN beats accepted in the current run.

## Operation
- States are IDLE, WALK, RUN and DONE.
- WALK exists only under the macro in Configuration.
- **Lane seeds:**
  - Lane i (i=0..3) seed = SEED + i*32'h9E3779B9, mod 2^32.
  - A computed seed of 0 is replaced by 32'h1.
- **Lane step:** next = (x >> 1) ^ (x[0] ? 32'h80200003 : 0). This is a Galois LFSR with polynomial x^32+x^22+x^2+x+1.
- **Data mapping:** `out_data` = {lane3, lane2, lane1, lane0} in RUN; the walk pattern in WALK; all zeros whenever `out_valid`=0.
- **IDLE:**
  - Outputs are low.
  - `start`=1 loads the lane seeds, clears `vec_count`, and moves to WALK (macro on) or RUN (macro off).
- **RUN:**
  - `out_valid`=1.
  - On a beat where `out_valid`&&`out_ready`, all lanes step once and `vec_count` increments.
  - If `vec_count` was NVEC-1 at that accept, the state moves to DONE.
- **DONE:**
  - `done`=1 and `vec_count` holds at NVEC.
  - `start`=1 behaves exactly as it does in IDLE: reseed and restart.
- **Handshake:**
  - While `out_valid`=1 and `out_ready`=0, `out_data` and the lane registers are held stable.
  - `out_valid` never drops before an accept.
- `start` during WALK or RUN is ignored.
- `vec_count` counts RUN beats only; 16-bit, with no wrap possible given the NVEC range.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `vec_count`=0, lanes=seeds.
- `rst` asserted mid-run forces the reset values immediately, with no clock edge required. Any in-flight beat is dropped.
- `start` sampled at edge k: `out_valid`=1 and `busy`=1 are visible after edge k.
- A beat is accepted at the edge where `out_valid`&&`out_ready`. The next beat is visible after that same edge, so one beat per cycle is sustained with `out_ready` held high.
- The final accept at edge m gives `done`=1, `busy`=0 and `out_valid`=0 after edge m.
- `start` and `rst` asserted together: `rst` wins.

## Configuration
The macro is `COSIM_STIM_WALK_EN`.
- **Defined:**
  - After `start`, the block enters WALK and emits 128 beats, `out_data` = 128'b1 << j for j=0..127.
  - The 7-bit walk index advances on each accept.
  - After accept j=127 the state moves to RUN.
  - WALK beats do not change the lanes or `vec_count`.
- **Undefined:** the WALK state, the walk index and the walk mux are absent, and `start` goes straight to RUN.

## Structure
- Package `cosim_stim_pkg` holds:
  - the state enum;
  - `LFSR_TAPS` = 32'h80200003;
  - `SEED_INC` = 32'h9E3779B9;
  - `NLANES` = 4.
- Sub-module `cosim_lfsr32` implements one lane: seed load, step-enable, and output of the current value. It is instantiated NLANES times in a generate loop with the per-lane seed as a parameter.
- The FSM, counter and output mux live in the top.

## Test plan
1. **Reset:** assert `rst` and then deassert, no `start` → all outputs 0 for 10 cycles.
2. **Basic run:** SEED=1, NVEC=4, `out_ready`=1, pulse `start`, macro off:
   - beat0 = {32'hDAA66D2C, 32'h3C6EF373, 32'h9E3779BA, 32'h00000001};
   - beat1 has lane0 = 32'h80200003;
   - 4 beats total, then `done`=1, `vec_count`=4, `out_valid`=0.
3. **Backpressure:** drop `out_ready` for 3 cycles on beat1 → `out_data` holds beat1 and `vec_count` stays 1. On release the sequence resumes unchanged.
4. **Start rules:**
   - `start` pulsed mid-RUN is ignored and the count continues.
   - `start` in DONE restarts the run, and beat0 matches test 2 exactly.
5. **Async reset:** assert `rst` between edges after beat2 → outputs go to 0 before the next edge. A subsequent `start` reproduces the test 2 sequence.
6. **Macro on, NVEC=2:**
   - beats 0..127 are 128'h1, 128'h2, …, 1<<127;
   - beat 128 equals test 2 beat0;
   - `done` follows 130 total accepts, with `vec_count`=2.
